div_rem_unit: RTL and testbench

//  Iterative RV32M divide/remainder unit: DIV, DIVU, REM, REMU. Inverse companion of the Karatsuba/Booth multiplier.

---
 rtl/mriscv_m_pkg.sv | 34 +++
 rtl/div_core_u.sv | 69 ++++++
 rtl/div_rem_unit.sv | 149 ++++++++++++++
 tb/tb_div_rem_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mriscv_m_pkg.sv
// Shared RV32M definitions: operand width, codif encodings, funct3 fields and divider FSM states.
// Used by div_rem_unit and its unsigned restoring core.
package mriscv_m_pkg;

    localparam int XLEN    = 32;
    localparam int CNT_BIT = 6;

    localparam logic [6:0] OPC_OP = 7'b0110011;

    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [11:0] CODIF_MUL  = {2'b01, F3_MUL,  OPC_OP};
    localparam logic [11:0] CODIF_DIV  = {2'b01, F3_DIV,  OPC_OP};
    localparam logic [11:0] CODIF_DIVU = {2'b01, F3_DIVU, OPC_OP};
    localparam logic [11:0] CODIF_REM  = {2'b01, F3_REM,  OPC_OP};
    localparam logic [11:0] CODIF_REMU = {2'b01, F3_REMU, OPC_OP};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_core_u.sv
// Unsigned restoring divider datapath: one quotient bit per step, W+1-bit compare/subtract.
// load_i seeds dividend/divisor and clears rem/counter; last_o flags the final step.
module div_core_u
    import mriscv_m_pkg::*;
#(
    parameter int W  = XLEN,
    parameter int CW = CNT_BIT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quo_o,
    output logic [W-1:0] rem_o,
    output logic         last_o
);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W:0] shift_rem;
    logic [W:0] diff;
    logic       ge;

    always_comb begin
        shift_rem = {rem_q, quo_q[W-1]};
        diff      = shift_rem - {1'b0, div_q};
        ge        = (shift_rem >= {1'b0, div_q});

        rem_d = rem_q;
        quo_d = quo_q;
        div_d = div_q;
        cnt_d = cnt_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            div_d = divisor_i;
            cnt_d = '0;
        end else if (step_i) begin
            // when ge the difference is below the divisor, so W bits hold it
            rem_d = ge ? diff[W-1:0] : shift_rem[W-1:0];
            quo_d = {quo_q[W-2:0], ge};
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign quo_o  = quo_q;
    assign rem_o  = rem_q;
    assign last_o = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/div_rem_unit.sv
// RV32M DIV/DIVU/REM/REMU: decode, control FSM, sign fix-up and RISC-V special cases around div_core_u.
// Optional DIV_SPECIAL_FAST_EN: divide-by-zero and signed overflow finish straight from LOAD.
module div_rem_unit
    import mriscv_m_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            Enable,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [11:0]     codif,
    output logic [XLEN-1:0] rd,
    output logic            is_oper,
    output logic            Done
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e state_q, state_d;

    logic [XLEN-1:0] result_q, result_d;
    logic            qneg_q, rneg_q, isrem_q, div0_q, ovf_q;

    logic dec_signed, dec_rem, start;
    logic div0_in, ovf_in, neg1, neg2;
    logic core_load, core_step, core_last;
    logic [XLEN-1:0] core_quo, core_rem, q_fix, r_fix, fix_res;

    assign is_oper    = (codif == CODIF_DIV) || (codif == CODIF_DIVU) ||
                        (codif == CODIF_REM) || (codif == CODIF_REMU);
    assign dec_signed = ~codif[7];
    assign dec_rem    = codif[8];
    assign start      = Enable & is_oper;

    assign neg1    = dec_signed & rs1[XLEN-1];
    assign neg2    = dec_signed & rs2[XLEN-1];
    assign div0_in = (rs2 == '0);
    assign ovf_in  = dec_signed & (rs1 == INT_MIN) & (rs2 == '1);

    div_core_u #(.W(XLEN), .CW(CNT_BIT)) u_core (
        .clk        (clk),
        .reset      (reset),
        .load_i     (core_load),
        .step_i     (core_step),
        .dividend_i (abs_if(rs1, neg1)),
        .divisor_i  (abs_if(rs2, neg2)),
        .quo_o      (core_quo),
        .rem_o      (core_rem),
        .last_o     (core_last)
    );

    // sign-fixed rem already equals the original rs1 on divide-by-zero, so only q needs forcing there
    always_comb begin
        q_fix = qneg_q ? (~core_quo + 1'b1) : core_quo;
        r_fix = rneg_q ? (~core_rem + 1'b1) : core_rem;
        if (div0_q) begin
            q_fix = '1;
        end
        if (ovf_q) begin
            q_fix = INT_MIN;
            r_fix = '0;
        end
        fix_res = isrem_q ? r_fix : q_fix;
    end

`ifdef DIV_SPECIAL_FAST_EN
    logic [XLEN-1:0] special_res;
    always_comb begin
        if (div0_in) special_res = dec_rem ? rs1 : '1;
        else         special_res = dec_rem ? '0 : INT_MIN;
    end
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        core_load = 1'b0;
        core_step = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                if (!Enable) begin
                    state_d = IDLE;
                end else begin
                    core_load = 1'b1;
                    state_d   = ITER;
`ifdef DIV_SPECIAL_FAST_EN
                    if (div0_in || ovf_in) begin
                        state_d  = DONE;
                        result_d = special_res;
                    end
`endif
                end
            end
            ITER: begin
                if (!Enable) begin
                    state_d = IDLE;
                end else begin
                    core_step = 1'b1;
                    if (core_last) state_d = FIX;
                end
            end
            FIX: begin
                if (!Enable) begin
                    state_d = IDLE;
                end else begin
                    result_d = fix_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (!Enable) begin
                    state_d  = IDLE;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = IDLE;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            isrem_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (core_load) begin
                qneg_q  <= neg1 ^ neg2;
                rneg_q  <= neg1;
                isrem_q <= dec_rem;
                div0_q  <= div0_in;
                ovf_q   <= ovf_in;
            end
        end
    end

    assign Done = (state_q == DONE);
    assign rd   = is_oper ? result_q : 'z;

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed vector bench for div_rem_unit: results, latency, hold/release, abort and reset corner cases.
module tb_div_rem_unit;
    import mriscv_m_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        Enable;
    logic [31:0] rs1, rs2;
    logic [11:0] codif;
    logic [31:0] rd;
    logic        is_oper;
    logic        Done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] codif;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs[16];

    div_rem_unit dut (
        .clk     (clk),
        .reset   (reset),
        .Enable  (Enable),
        .rs1     (rs1),
        .rs2     (rs2),
        .codif   (codif),
        .rd      (rd),
        .is_oper (is_oper),
        .Done    (Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input vec_t v, input string name);
        int lat;
        int exp_lat;
        lat = 0;
        exp_lat = 35;
`ifdef DIV_SPECIAL_FAST_EN
        if (v.special) exp_lat = 2;
`endif
        tick(1);
        codif  = v.codif;
        rs1    = v.a;
        rs2    = v.b;
        Enable = 1'b1;
        for (int e = 1; e <= 40 && lat == 0; e++) begin
            tick(1);
            if (Done) lat = e;
            else if (rd !== 32'h0) chk({name, " rd-before-done"}, rd, 32'h0);
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " rd"}, rd, v.exp);
        rs1 = 32'h0;
        rs2 = 32'h1;
        tick(1);
        chk({name, " hold-done"}, {31'b0, Done}, 32'h1);
        chk({name, " hold-rd"}, rd, v.exp);
        Enable = 1'b0;
        tick(1);
        chk({name, " release-done"}, {31'b0, Done}, 32'h0);
        chk({name, " release-rd"}, rd, 32'h0);
    endtask

    initial begin
        int seen_done;
        vecs[0]  = '{CODIF_DIV,  32'd100,      32'd7,        32'h0000000E, 1'b0};
        vecs[1]  = '{CODIF_REM,  32'd100,      32'd7,        32'h00000002, 1'b0};
        vecs[2]  = '{CODIF_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{CODIF_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
        vecs[4]  = '{CODIF_DIVU, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 1'b0};
        vecs[5]  = '{CODIF_REMU, 32'hFFFFFFF9, 32'd2,        32'h00000001, 1'b0};
        vecs[6]  = '{CODIF_DIVU, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{CODIF_REMU, 32'h12345678, 32'd0,        32'h12345678, 1'b1};
        vecs[8]  = '{CODIF_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1};
        vecs[9]  = '{CODIF_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[10] = '{CODIF_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[11] = '{CODIF_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[12] = '{CODIF_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[13] = '{CODIF_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vecs[14] = '{CODIF_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[15] = '{CODIF_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0};

        reset  = 1'b0;
        Enable = 1'b0;
        rs1    = 32'h0;
        rs2    = 32'h0;
        codif  = CODIF_DIV;
        tick(2);
        chk("reset done", {31'b0, Done}, 32'h0);
        chk("reset rd", rd, 32'h0);
        chk("decode div is_oper", {31'b0, is_oper}, 32'h1);
        reset = 1'b1;
        tick(1);

        codif = CODIF_MUL;
        #1;
        chk("decode mul is_oper", {31'b0, is_oper}, 32'h0);
        Enable = 1'b1;
        tick(3);
        chk("mul no start", {31'b0, Done}, 32'h0);
        Enable = 1'b0;

        for (int i = 0; i < 16; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // abort mid-iteration, then a fresh op must still work
        tick(1);
        codif  = CODIF_DIVU;
        rs1    = 32'hFFFFFFFF;
        rs2    = 32'h1;
        Enable = 1'b1;
        tick(12);
        chk("abort rd mid-iter", rd, 32'h0);
        Enable = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (Done) seen_done++;
        end
        chk("abort done never", seen_done, 0);
        run_op('{CODIF_DIVU, 32'd9, 32'd3, 32'd3, 1'b0}, "reissue divu");

        // synchronous reset during iteration
        tick(1);
        codif  = CODIF_DIV;
        rs1    = 32'd100;
        rs2    = 32'd7;
        Enable = 1'b1;
        tick(15);
        reset = 1'b0;
        tick(1);
        chk("midreset done", {31'b0, Done}, 32'h0);
        chk("midreset rd", rd, 32'h0);
        reset  = 1'b1;
        Enable = 1'b0;
        tick(40);
        chk("midreset stays idle", {31'b0, Done}, 32'h0);
        run_op('{CODIF_REM, 32'd100, 32'd7, 32'd2, 1'b0}, "post-reset rem");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
